neighbor_counter: RTL and testbench
===================================

# neighbor_counter

Sequential mine-neighbour counter for the minesweeper board. Given a cell coordinate, it reads the mine bitmap RAM once for each in-bounds neighbour and sums the mine bits through the existing 8-bit `adder` stage. It returns the 0–8 count that the reveal/flood-fill logic and the display path consume. It sits between the board bitmap RAM (upstream) and the reveal controller (downstream).

## Interface
Parameters:
- ROWS, 16, board height in cells
- COLS, 16, board width in cells
- RW, 4, row coordinate width
- CW, 4, column coordinate width
- AW, 8, bitmap address width (address = row*COLS + col)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  request pulse; sampled only while busy=0
- row  in  RW  centre cell row, latched on accepted start
- col  in  CW  centre cell column, latched on accepted start
- mem_rd  out  1  bitmap read strobe
- mem_addr  out  AW  bitmap read address, valid when mem_rd=1
- mem_data  in  1  mine bit, valid exactly one cycle after mem_rd
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when count is valid
- count  out  4  neighbour mine count, held until the next accepted start

## Operation
- States:
  - IDLE: start=1 latches row/col, clears acc and k, then goes to SCAN.
  - SCAN: one neighbour per cycle, k=0..N-1; after k=N-1 goes to DRAIN.
  - DRAIN: one cycle; goes to DONE.
  - DONE: one cycle; goes to IDLE, or goes to SCAN if start=1.
- Neighbour order (dr,dc) for N=8: (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1).
- In SCAN, if row+dr and col+dc are both in [0,ROWS-1] and [0,COLS-1]:
  - mem_rd=1, mem_addr=(row+dr)*COLS+(col+dc).
  - Otherwise mem_rd=0 and that neighbour contributes 0.
  - Bounds are computed signed, one bit wider than RW/CW; there is no wrap-around.
- A registered copy of mem_rd (rd_q) qualifies accumulation. When rd_q=1, acc is updated with acc = adder(A=acc, B={7'b0,mem_data}, CI=0).Y. CO is unused and must never be set (max 9).
- count = acc[3:0], registered in DRAIN→DONE.
- If the latched row≥ROWS or col≥COLS, no reads are issued, count=0, and latency is unchanged.
- start while busy=1 is ignored. start in the DONE cycle is accepted (back-to-back).

## Timing
- Start accepted at edge T: SCAN occupies T+1..T+N, DRAIN is T+N+1, and done=1 in cycle T+N+2.
  - Latency is fixed at N+2 cycles regardless of bounds.
- busy=1 from T+1 through T+N+1. busy=0 in IDLE and DONE.
- At most one mem_rd per cycle and at most N per request.
- Reset values: busy=0, done=0, mem_rd=0, mem_addr=0, count=0, state=IDLE, acc=0, rd_q=0.
- Reset mid-scan forces the above immediately (asynchronously). Any read data returning after reset is ignored; a new start after reset release behaves normally.

## Configuration
- NEIGHBOR_SELF_EN defined:
  - N=9; the centre (0,0) is inserted as index 4, between (0,-1) and (0,+1).
  - count covers the 3×3 block (0–9), used by the first-click safety check.
  - Latency becomes 11 cycles.
- Undefined: N=8, centre never read, latency 10 cycles.

## Structure
- Shared package ms_pkg holds:
  - ROWS/COLS defaults
  - the neighbour offset table (both variants, selected by the macro)
  - the state enum {IDLE, SCAN, DRAIN, DONE}
  - the count width constant
- One sub-module instance: adder (8-bit ripple adder) as the accumulation datapath.
- FSM, bounds check and address generation are local.

## Test plan
All scenarios use a 16×16 board with a behavioural 1-cycle-latency bitmap RAM.
- Centre (5,5), all 8 neighbours mined → 8 mem_rd pulses at T+1..T+8, done at T+10, count=8.
- Corner (0,0), mines at (0,1) and (1,1) → exactly 3 reads (addresses 1, 16, 17), count=2, done at T+10.
- Only (5,5) mined, start at (5,5) → count=0 without NEIGHBOR_SELF_EN; count=1 and done at T+11 with it.
- start pulsed at T+3 while busy → ignored, count unchanged. start in the done cycle → second scan begins next cycle and completes normally.
- rst asserted at T+4 → busy/done/mem_rd/count=0 immediately. After release, start at (5,5) with 3 mined neighbours → count=3.
- start with row=16 → no mem_rd, count=0, done at T+10.

Source files
------------

// File: rtl/ms_pkg.sv
// rtl/ms_pkg.sv - shared constants, scan states and neighbour offset table; NEIGHBOR_SELF_EN selects the 3x3 variant
package ms_pkg;

    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;
    localparam int CNT_W    = 4;
    localparam int KW       = 4;

`ifdef NEIGHBOR_SELF_EN
    localparam int N_NB = 9;
`else
    localparam int N_NB = 8;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    // Row offset of neighbour k, row-major order around the centre cell
    function automatic logic signed [1:0] nb_dr(input logic [KW-1:0] k);
        logic signed [1:0] d;
        case (k)
`ifdef NEIGHBOR_SELF_EN
            4'd0, 4'd1, 4'd2: d = 2'sb11;
            4'd6, 4'd7, 4'd8: d = 2'sb01;
`else
            4'd0, 4'd1, 4'd2: d = 2'sb11;
            4'd5, 4'd6, 4'd7: d = 2'sb01;
`endif
            default:          d = 2'sb00;
        endcase
        return d;
    endfunction

    function automatic logic signed [1:0] nb_dc(input logic [KW-1:0] k);
        logic signed [1:0] d;
        case (k)
`ifdef NEIGHBOR_SELF_EN
            4'd0, 4'd3, 4'd6: d = 2'sb11;
            4'd2, 4'd5, 4'd8: d = 2'sb01;
`else
            4'd0, 4'd3, 4'd5: d = 2'sb11;
            4'd2, 4'd4, 4'd7: d = 2'sb01;
`endif
            default:          d = 2'sb00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - 8-bit ripple-carry adder used as the mine-count accumulation stage
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] y,
    output logic       co
);

    logic [8:0] c;

    always_comb begin
        y = '0;
        c = {8'b0, ci};
        for (int i = 0; i < 8; i++) begin
            y[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        co = c[8];
    end

endmodule

// File: rtl/neighbor_counter.sv
// rtl/neighbor_counter.sv - sequential mine-neighbour counter; NEIGHBOR_SELF_EN also counts the centre cell
module neighbor_counter
    import ms_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int RW   = 4,
    parameter int CW   = 4,
    parameter int AW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RW-1:0]    row,
    input  logic [CW-1:0]    col,
    output logic             mem_rd,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    state_t          state;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [KW-1:0]   k;
    logic [7:0]      acc;
    logic            rd_q;

    logic [RW-1:0]   sel_row;
    logic [CW-1:0]   sel_col;
    logic [KW-1:0]   sel_k;
    logic signed [1:0] dr;
    logic signed [1:0] dc;
    logic signed [RW:0] rr;
    logic signed [CW:0] cc;
    logic            nb_ok;
    logic [AW-1:0]   nb_addr;
    logic [7:0]      sum;
    logic            co_unused;
    logic [7:0]      acc_next;

    // Outputs are registered, so the read for neighbour k+1 is prepared while k is on the bus
    always_comb begin
        sel_row = row;
        sel_col = col;
        sel_k   = '0;
        if (state == SCAN) begin
            sel_row = row_q;
            sel_col = col_q;
            sel_k   = k + KW'(1);
        end
        dr = nb_dr(sel_k);
        dc = nb_dc(sel_k);
        rr = $signed({1'b0, sel_row}) + $signed({{(RW-1){dr[1]}}, dr});
        cc = $signed({1'b0, sel_col}) + $signed({{(CW-1){dc[1]}}, dc});
        nb_ok = !rr[RW] && (int'(rr[RW-1:0]) < ROWS)
             && !cc[CW] && (int'(cc[CW-1:0]) < COLS)
             && (int'(sel_row) < ROWS) && (int'(sel_col) < COLS);
        nb_addr = AW'(rr[RW-1:0]) * AW'(COLS) + AW'(cc[CW-1:0]);
    end

    adder u_adder (
        .a  (acc),
        .b  ({7'b0, mem_data}),
        .ci (1'b0),
        .y  (sum),
        .co (co_unused)
    );

    assign acc_next = rd_q ? sum : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            k        <= '0;
            acc      <= '0;
            rd_q     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
        end else begin
            rd_q <= mem_rd;
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SCAN;
                        row_q    <= row;
                        col_q    <= col;
                        k        <= '0;
                        acc      <= '0;
                        busy     <= 1'b1;
                        mem_rd   <= nb_ok;
                        mem_addr <= nb_addr;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        mem_rd <= 1'b0;
                    end
                end
                SCAN: begin
                    acc <= acc_next;
                    if (k == KW'(N_NB - 1)) begin
                        state  <= DRAIN;
                        mem_rd <= 1'b0;
                    end else begin
                        k        <= k + KW'(1);
                        mem_rd   <= nb_ok;
                        mem_addr <= nb_addr;
                    end
                end
                DRAIN: begin
                    // Last read's data lands this cycle, so count takes the adder result directly
                    acc   <= acc_next;
                    count <= acc_next[CNT_W-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_counter.sv
// tb/tb_neighbor_counter.sv - randomized self-checking bench for neighbor_counter against a 3x3 scan model
module tb_neighbor_counter;

    localparam int ROWS = 16;
    localparam int COLS = 16;
    localparam int RW   = 5;
    localparam int CW   = 5;
    localparam int AW   = 8;
`ifdef NEIGHBOR_SELF_EN
    localparam bit SELF = 1'b1;
`else
    localparam bit SELF = 1'b0;
`endif
    localparam int NB  = SELF ? 9 : 8;
    localparam int LAT = NB + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [RW-1:0] row = '0;
    logic [CW-1:0] col = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_data = 1'b0;
    logic          busy;
    logic          done;
    logic [3:0]    count;

    bit mines [ROWS*COLS];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int busy_q[$];
    int exp_addr_q[$];
    int exp_idx_q[$];

    neighbor_counter #(
        .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW), .AW(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .row      (row),
        .col      (col),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) mem_data <= mem_rd ? mines[mem_addr] : 1'($urandom);

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_addr_q.push_back(int'(mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (busy) busy_q.push_back(cyc);
    end

    // Reference: walk the 3x3 window row-major, skip the centre unless it is counted
    function automatic int model_scan(input int r, input int c);
        int n = 0;
        int k = 0;
        exp_addr_q.delete();
        exp_idx_q.delete();
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr == 0 && dc == 0 && !SELF) continue;
                if (r < ROWS && c < COLS && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS) begin
                    exp_addr_q.push_back((r + dr) * COLS + c + dc);
                    exp_idx_q.push_back(k);
                    n += int'(mines[(r + dr) * COLS + c + dc]);
                end
                k++;
            end
        end
        return n;
    endfunction

    task automatic clear_mines();
        for (int i = 0; i < ROWS * COLS; i++) mines[i] = 1'b0;
    endtask

    task automatic rand_mines();
        for (int i = 0; i < ROWS * COLS; i++) mines[i] = ($urandom_range(0, 7) < 3);
    endtask

    task automatic do_scan(input int r, input int c, output int t0, output int dcyc, output logic [3:0] cnt);
        @(negedge clk);
        row = RW'(r);
        col = CW'(c);
        start = 1'b1;
        rd_addr_q.delete();
        rd_cyc_q.delete();
        busy_q.delete();
        @(negedge clk);
        start = 1'b0;
        t0 = cyc - 1;
        dcyc = -1;
        cnt = 'x;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                dcyc = cyc;
                cnt = count;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd got=%b want=0", mem_rd); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        rst = 1'b0;
    endtask

    task automatic test_centre();
        int t0, dcyc;
        logic [3:0] cnt;
        clear_mines();
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) mines[(5 + dr) * COLS + 5 + dc] = 1'b1;
        do_scan(5, 5, t0, dcyc, cnt);
        total++; if (cnt !== 4'd8) begin bad++; $display("FAIL centre_count got=%0d want=8", cnt); end
        total++; if (rd_cyc_q.size() != NB) begin bad++; $display("FAIL centre_reads got=%0d want=%0d", rd_cyc_q.size(), NB); end
        for (int i = 0; i < rd_cyc_q.size(); i++) begin
            total++;
            if (rd_cyc_q[i] != t0 + 1 + i) begin bad++; $display("FAIL centre_rd_cycle[%0d] got=%0d want=%0d", i, rd_cyc_q[i], t0 + 1 + i); end
        end
        total++; if (dcyc != t0 + LAT) begin bad++; $display("FAIL centre_latency got=%0d want=%0d", dcyc - t0, LAT); end
        total++; if (busy_q.size() != NB + 1) begin bad++; $display("FAIL centre_busy_cycles got=%0d want=%0d", busy_q.size(), NB + 1); end
        total++; if (busy_q.size() == 0 || busy_q[0] != t0 + 1) begin bad++; $display("FAIL centre_busy_start want_cycle=%0d", t0 + 1); end
    endtask

    task automatic test_corner();
        int t0, dcyc;
        logic [3:0] cnt;
        int exp[$];
        clear_mines();
        mines[0 * COLS + 1] = 1'b1;
        mines[1 * COLS + 1] = 1'b1;
        exp = {1, 16, 17};
        if (SELF) exp.push_front(0);
        do_scan(0, 0, t0, dcyc, cnt);
        total++; if (cnt !== 4'd2) begin bad++; $display("FAIL corner_count got=%0d want=2", cnt); end
        total++; if (rd_addr_q.size() != exp.size()) begin bad++; $display("FAIL corner_reads got=%0d want=%0d", rd_addr_q.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < rd_addr_q.size(); i++) begin
            total++;
            if (rd_addr_q[i] != exp[i]) begin bad++; $display("FAIL corner_addr[%0d] got=%0d want=%0d", i, rd_addr_q[i], exp[i]); end
        end
        total++; if (dcyc != t0 + LAT) begin bad++; $display("FAIL corner_latency got=%0d want=%0d", dcyc - t0, LAT); end
    endtask

    task automatic test_self();
        int t0, dcyc;
        logic [3:0] cnt;
        clear_mines();
        mines[5 * COLS + 5] = 1'b1;
        do_scan(5, 5, t0, dcyc, cnt);
        total++; if (cnt !== (SELF ? 4'd1 : 4'd0)) begin bad++; $display("FAIL self_count got=%0d want=%0d", cnt, SELF ? 1 : 0); end
        total++; if (dcyc != t0 + LAT) begin bad++; $display("FAIL self_latency got=%0d want=%0d", dcyc - t0, LAT); end
    endtask

    task automatic test_out_of_range();
        int t0, dcyc;
        logic [3:0] cnt;
        int rs[2] = '{16, 4};
        int cs[2] = '{3, 20};
        rand_mines();
        for (int i = 0; i < 2; i++) begin
            do_scan(rs[i], cs[i], t0, dcyc, cnt);
            total++; if (rd_addr_q.size() != 0) begin bad++; $display("FAIL oob_reads[%0d] got=%0d want=0", i, rd_addr_q.size()); end
            total++; if (cnt !== 4'd0) begin bad++; $display("FAIL oob_count[%0d] got=%0d want=0", i, cnt); end
            total++; if (dcyc != t0 + LAT) begin bad++; $display("FAIL oob_latency[%0d] got=%0d want=%0d", i, dcyc - t0, LAT); end
        end
    endtask

    task automatic test_random();
        int t0, dcyc, r, c, e;
        logic [3:0] cnt;
        for (int n = 0; n < 24; n++) begin
            rand_mines();
            r = $urandom_range(0, ROWS + 1);
            c = $urandom_range(0, COLS + 1);
            e = model_scan(r, c);
            do_scan(r, c, t0, dcyc, cnt);
            total++; if (cnt !== 4'(e)) begin bad++; $display("FAIL rand_count (%0d,%0d) got=%0d want=%0d", r, c, cnt, e); end
            total++; if (rd_addr_q.size() != exp_addr_q.size()) begin bad++; $display("FAIL rand_reads (%0d,%0d) got=%0d want=%0d", r, c, rd_addr_q.size(), exp_addr_q.size()); end
            for (int i = 0; i < exp_addr_q.size() && i < rd_addr_q.size(); i++) begin
                total++;
                if (rd_addr_q[i] != exp_addr_q[i] || rd_cyc_q[i] != t0 + 1 + exp_idx_q[i]) begin
                    bad++;
                    $display("FAIL rand_read[%0d] (%0d,%0d) got=%0d@%0d want=%0d@%0d", i, r, c, rd_addr_q[i], rd_cyc_q[i] - t0, exp_addr_q[i], 1 + exp_idx_q[i]);
                end
            end
            total++; if (dcyc != t0 + LAT) begin bad++; $display("FAIL rand_latency (%0d,%0d) got=%0d want=%0d", r, c, dcyc - t0, LAT); end
        end
    endtask

    task automatic test_ignore_back_to_back();
        int t0, t2, dcyc, e1, e2, n1;
        logic [3:0] cnt;
        clear_mines();
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) mines[(2 + dr) * COLS + 2 + dc] = 1'b1;
        mines[6 * COLS + 10] = 1'b1;
        mines[8 * COLS + 8] = 1'b1;
        mines[2 * COLS + 11] = 1'b1;
        mines[3 * COLS + 13] = 1'b1;
        mines[4 * COLS + 12] = 1'b1;
        e1 = model_scan(7, 9);
        n1 = exp_addr_q.size();
        @(negedge clk);
        row = 5'd7; col = 5'd9; start = 1'b1;
        rd_addr_q.delete(); rd_cyc_q.delete(); busy_q.delete();
        @(negedge clk);
        start = 1'b0;
        t0 = cyc - 1;
        dcyc = -1;
        cnt = 'x;
        for (int i = 0; i < 40; i++) begin
            if (cyc == t0 + 3) begin row = 5'd2; col = 5'd2; start = 1'b1; end
            else start = 1'b0;
            if (done) begin dcyc = cyc; cnt = count; break; end
            @(negedge clk);
        end
        total++; if (cnt !== 4'(e1)) begin bad++; $display("FAIL ignore_count got=%0d want=%0d", cnt, e1); end
        total++; if (dcyc != t0 + LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", dcyc - t0, LAT); end
        total++; if (rd_addr_q.size() != n1) begin bad++; $display("FAIL ignore_reads got=%0d want=%0d", rd_addr_q.size(), n1); end

        e2 = model_scan(3, 12);
        row = 5'd3; col = 5'd12; start = 1'b1;
        rd_addr_q.delete(); rd_cyc_q.delete(); busy_q.delete();
        @(negedge clk);
        start = 1'b0;
        t2 = cyc - 1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b want=1", busy); end
        dcyc = -1;
        cnt = 'x;
        for (int i = 0; i < 40; i++) begin
            if (done) begin dcyc = cyc; cnt = count; break; end
            @(negedge clk);
        end
        total++; if (cnt !== 4'(e2)) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", cnt, e2); end
        total++; if (dcyc != t2 + LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", dcyc - t2, LAT); end
        total++; if (rd_addr_q.size() != exp_addr_q.size()) begin bad++; $display("FAIL b2b_reads got=%0d want=%0d", rd_addr_q.size(), exp_addr_q.size()); end
    endtask

    task automatic test_reset_mid_scan();
        int t0, dcyc;
        logic [3:0] cnt;
        rand_mines();
        @(negedge clk);
        row = 5'd5; col = 5'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc - 1;
        while (cyc < t0 + 4) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL midrst_mem_rd got=%b want=0", mem_rd); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", count); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_mines();
        mines[4 * COLS + 4] = 1'b1;
        mines[5 * COLS + 6] = 1'b1;
        mines[6 * COLS + 5] = 1'b1;
        do_scan(5, 5, t0, dcyc, cnt);
        total++; if (cnt !== 4'd3) begin bad++; $display("FAIL after_rst_count got=%0d want=3", cnt); end
        total++; if (dcyc != t0 + LAT) begin bad++; $display("FAIL after_rst_latency got=%0d want=%0d", dcyc - t0, LAT); end
    endtask

    initial begin
        test_reset();
        test_centre();
        test_corner();
        test_self();
        test_out_of_range();
        test_random();
        test_ignore_back_to_back();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
